// File: rtl/top_fsm_pkg.sv
// Shared definitions for the Top_FSM timer slice: state encoding and default widths.
package top_fsm_pkg;

  localparam int W_DEF     = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/timer_load_ctrl.sv
// Interval-timer controller for counter_32_rev: loads the counter, watches Rc,
// and emits a tick per expiry in one-shot or auto-reload mode.
module timer_load_ctrl
  import top_fsm_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_reload,
  input  logic             dir_up,
  input  logic [W-1:0]     period,
  input  logic             Rc,
  output logic             s,
  output logic             Load,
  output logic [W-1:0]     PData,
  output logic             tick,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] expire_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     PER_ZERO = '0;

  state_t           state_q, state_n;
  logic             reload_q, reload_n;
  logic             s_n, load_n, tick_n, busy_n, err_n;
  logic [W-1:0]     pdata_n;
  logic [CNT_W-1:0] cnt_n;

  assign state_dbg = state_q;

  // start is a level sampled only in IDLE; Load is a single-cycle strobe that
  // the counter captures on the following edge.
  always_comb begin
    state_n  = state_q;
    reload_n = reload_q;
    s_n      = s;
    load_n   = 1'b0;
    pdata_n  = PData;
    tick_n   = 1'b0;
    busy_n   = busy;
    err_n    = 1'b0;
    cnt_n    = expire_cnt;

    if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (period == PER_ZERO) begin
              err_n = 1'b1;
            end else begin
              state_n  = LOAD;
              reload_n = mode_reload;
              s_n      = dir_up;
              pdata_n  = dir_up ? ~period : period;
              load_n   = 1'b1;
              busy_n   = 1'b1;
            end
          end
        end
        LOAD: begin
          state_n = RUN;
          busy_n  = 1'b1;
        end
        RUN: begin
          if (Rc) begin
            tick_n = 1'b1;
            if (expire_cnt != CNT_MAX) cnt_n = expire_cnt + CNT_ONE;
            if (reload_q) begin
              state_n = LOAD;
              load_n  = 1'b1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      reload_q   <= 1'b0;
      s          <= 1'b0;
      Load       <= 1'b0;
      PData      <= '0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      expire_cnt <= '0;
    end else begin
      state_q    <= state_n;
      reload_q   <= reload_n;
      s          <= s_n;
      Load       <= load_n;
      PData      <= pdata_n;
      tick       <= tick_n;
      busy       <= busy_n;
      err        <= err_n;
      expire_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_timer_load_ctrl.sv
// Directed bench for timer_load_ctrl with a behavioural counter_32_rev closing
// the Rc loop; a second instance with CNT_W=2 shares the stimulus.
module tb_timer_load_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode_reload = 1'b0;
  logic          dir_up = 1'b0;
  logic [W-1:0]  period = '0;

  logic          rc, s, load, tick, busy, err;
  logic [W-1:0]  pdata;
  logic [15:0]   expire_cnt;
  logic [1:0]    state_dbg;

  logic          rc2, s2, load2, tick2, busy2, err2;
  logic [W-1:0]  pdata2;
  logic [1:0]    expire_cnt2;
  logic [1:0]    state_dbg2;

  logic [W-1:0]  cnt, cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_load_ctrl #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_reload(mode_reload), .dir_up(dir_up), .period(period), .Rc(rc),
    .s(s), .Load(load), .PData(pdata), .tick(tick), .busy(busy), .err(err),
    .expire_cnt(expire_cnt), .state_dbg(state_dbg)
  );

  timer_load_ctrl #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_reload(mode_reload), .dir_up(dir_up), .period(period), .Rc(rc2),
    .s(s2), .Load(load2), .PData(pdata2), .tick(tick2), .busy(busy2), .err(err2),
    .expire_cnt(expire_cnt2), .state_dbg(state_dbg2)
  );

  // Reversible counter: counts every clock, Load overrides, Rc is combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= pdata;
    else if (s)    cnt <= cnt + 32'd1;
    else           cnt <= cnt - 32'd1;
  end
  assign rc = s ? (cnt == 32'hFFFF_FFFF) : (cnt == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt2 <= '0;
    else if (load2) cnt2 <= pdata2;
    else if (s2)    cnt2 <= cnt2 + 32'd1;
    else            cnt2 <= cnt2 - 32'd1;
  end
  assign rc2 = s2 ? (cnt2 == 32'hFFFF_FFFF) : (cnt2 == 32'd0);

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; mode_reload = 1'b0; dir_up = 1'b0; period = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the bench at the negedge right after the start-sampling edge.
  task automatic issue_start(input logic [W-1:0] p, input logic up, input logic rl);
    @(negedge clk);
    start = 1'b1; period = p; dir_up = up; mode_reload = rl;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    total++; if ({s, load, tick, busy, err} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {s, load, tick, busy, err}); end
    total++; if (pdata !== 32'd0 || expire_cnt !== 16'd0) begin bad++; $display("FAIL reset_data pdata=%h cnt=%0d exp=0/0", pdata, expire_cnt); end
    issue_start(32'd5, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1 || state_dbg !== 2'd2) begin bad++; $display("FAIL reset_pre_busy busy=%b state=%0d exp=1/2", busy, state_dbg); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL async_reset_state got=%0d exp=0", state_dbg); end
    total++; if ({s, load, tick, busy, err} !== 5'b0) begin bad++; $display("FAIL async_reset_flags got=%b exp=00000", {s, load, tick, busy, err}); end
    total++; if (pdata !== 32'd0 || expire_cnt !== 16'd0) begin bad++; $display("FAIL async_reset_data pdata=%h cnt=%0d exp=0/0", pdata, expire_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_oneshot();
    do_reset();
    issue_start(32'd5, 1'b0, 1'b0);
    total++; if (load !== 1'b1 || pdata !== 32'd5 || s !== 1'b0) begin bad++; $display("FAIL oneshot_load load=%b pdata=%h s=%b exp=1/5/0", load, pdata, s); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL oneshot_busy0 got=%b exp=1", busy); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (load !== 1'b0 || state_dbg !== 2'd2) begin bad++; $display("FAIL oneshot_run load=%b state=%0d exp=0/2", load, state_dbg); end
      end
      total++; if (tick !== (k == 7)) begin bad++; $display("FAIL oneshot_tick k=%0d got=%b exp=%b", k, tick, (k == 7)); end
      if (k == 7) begin
        total++; if (busy !== 1'b0 || expire_cnt !== 16'd1) begin bad++; $display("FAIL oneshot_done busy=%b cnt=%0d exp=0/1", busy, expire_cnt); end
      end
      if (k == 9) begin
        total++; if (state_dbg !== 2'd0 || load !== 1'b0) begin bad++; $display("FAIL oneshot_idle state=%0d load=%b exp=0/0", state_dbg, load); end
      end
    end
  endtask

  task automatic test_reload();
    do_reset();
    issue_start(32'd3, 1'b1, 1'b1);
    total++; if (pdata !== 32'hFFFF_FFFC || s !== 1'b1) begin bad++; $display("FAIL reload_pdata pdata=%h s=%b exp=fffffffc/1", pdata, s); end
    // Changes while busy must be ignored.
    period = 32'd9; dir_up = 1'b0; mode_reload = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++; if (tick !== (k % 5 == 0)) begin bad++; $display("FAIL reload_tick k=%0d got=%b exp=%b", k, tick, (k % 5 == 0)); end
      total++; if (load !== (k % 5 == 0)) begin bad++; $display("FAIL reload_load k=%0d got=%b exp=%b", k, load, (k % 5 == 0)); end
    end
    start = 1'b0;
    total++; if (expire_cnt !== 16'd4 || pdata !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reload_cnt cnt=%0d pdata=%h exp=4/fffffffc", expire_cnt, pdata); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++; if (state_dbg !== 2'd0 || busy !== 1'b0 || load !== 1'b0) begin bad++; $display("FAIL reload_stop state=%0d busy=%b load=%b exp=0/0/0", state_dbg, busy, load); end
  endtask

  task automatic test_stop_on_rc();
    do_reset();
    issue_start(32'd5, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    total++; if (state_dbg !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL stoprc_pre state=%0d busy=%b exp=2/1", state_dbg, busy); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++; if (tick !== 1'b0 || expire_cnt !== 16'd0) begin bad++; $display("FAIL stoprc_tick tick=%b cnt=%0d exp=0/0", tick, expire_cnt); end
    total++; if (state_dbg !== 2'd0 || busy !== 1'b0 || load !== 1'b0) begin bad++; $display("FAIL stoprc_idle state=%0d busy=%b load=%b exp=0/0/0", state_dbg, busy, load); end
    repeat (3) @(negedge clk);
    total++; if (tick !== 1'b0 || expire_cnt !== 16'd0 || pdata !== 32'd5) begin bad++; $display("FAIL stoprc_hold tick=%b cnt=%0d pdata=%h exp=0/0/5", tick, expire_cnt, pdata); end
  endtask

  task automatic test_period_zero();
    do_reset();
    issue_start(32'd0, 1'b1, 1'b1);
    total++; if (err !== 1'b1 || load !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_err err=%b load=%b busy=%b exp=1/0/0", err, load, busy); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL zero_state got=%0d exp=0", state_dbg); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++; if (err !== 1'b0 || load !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_after k=%0d err=%b load=%b busy=%b exp=0/0/0", k, err, load, busy); end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c;
    do_reset();
    issue_start(32'd1, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      total++; if (tick2 !== (k % 3 == 0)) begin bad++; $display("FAIL sat_tick k=%0d got=%b exp=%b", k, tick2, (k % 3 == 0)); end
      if (k % 3 == 0) begin
        exp_c = (k / 3 >= 3) ? 2'd3 : 2'(k / 3);
        total++; if (expire_cnt2 !== exp_c) begin bad++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, expire_cnt2, exp_c); end
      end
    end
    total++; if (expire_cnt !== 16'd5) begin bad++; $display("FAIL wide_cnt got=%0d exp=5", expire_cnt); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_stop_on_rc();
    test_period_zero();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
